// File: rtl/breathe_pkg.sv
// rtl/breathe_pkg.sv - shared constants for the breathing PWM channel
//
// Purpose: state encoding and default widths shared by breathe_pwm_channel
//          and pwm_compare.
// Ports:   none (package).
package breathe_pkg;

    localparam int PWM_BITS_DEF    = 8;
    localparam int PERIOD_BITS_DEF = 24;

    // Brightness steps in one full inhale+exhale for the default resolution.
    localparam int STEPS_PER_CYCLE = 1 << (PWM_BITS_DEF + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] INHALE = 2'd1;
    localparam logic [1:0] EXHALE = 2'd2;

endpackage

// File: rtl/breathe_pwm_channel_pwm_compare.sv
// rtl/breathe_pwm_channel_pwm_compare.sv - free-running PWM counter, compare and polarity register
//
// Purpose: turns a brightness level into a registered PWM drive.
// Ports:   clk, reset (async, active-high)
//          run    - 1 = count and compare; 0 = counter cleared, output at idle level
//          level  - brightness, on for `level` of every 2^PWM_BITS clocks
//          pwm_o  - registered drive, inverted when OUTPUT_ACTIVE_LOW=1
module pwm_compare
    import breathe_pkg::*;
#(
    parameter int PWM_BITS          = PWM_BITS_DEF,
    parameter bit OUTPUT_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [PWM_BITS-1:0] level,
    output logic                pwm_o
);

    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm_o   <= OUTPUT_ACTIVE_LOW;
        end else if (!run) begin
            pwm_cnt <= '0;
            pwm_o   <= OUTPUT_ACTIVE_LOW;
        end else begin
            // Wraps naturally at 2^PWM_BITS; strict '<' keeps level 0 fully dark.
            pwm_cnt <= pwm_cnt + CNT_ONE;
            pwm_o   <= (pwm_cnt < level) ^ OUTPUT_ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/breathe_pwm_channel.sv
// rtl/breathe_pwm_channel.sv - single-channel LED breathing generator
//
// Purpose: triangle brightness ramp 0 -> MAX -> 0, each step held for
//          `period` clocks, driving a PWM LED output.
// Ports:   clk, reset (async, active-high)
//          enable       - 1 = breathe, 0 = back to IDLE with LED dark
//          period       - clocks per brightness step (0 behaves as 1)
//          breathe_o    - registered PWM LED drive
//          level_o      - current brightness
//          cycle_done_o - one-clock pulse at the end of each inhale+exhale
//          busy_o       - channel is not idle
module breathe_pwm_channel
    import breathe_pkg::*;
#(
    parameter int PWM_BITS          = PWM_BITS_DEF,
    parameter int PERIOD_BITS       = PERIOD_BITS_DEF,
    parameter bit OUTPUT_ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    output logic                   breathe_o,
    output logic [PWM_BITS-1:0]    level_o,
    output logic                   cycle_done_o,
    output logic                   busy_o
);

    localparam logic [PWM_BITS-1:0]    LEVEL_MAX  = '1;
    localparam logic [PWM_BITS-1:0]    LEVEL_ONE  = PWM_BITS'(1);
    localparam logic [PERIOD_BITS-1:0] PERIOD_ONE = PERIOD_BITS'(1);

    logic [1:0]             state;
    logic [PERIOD_BITS-1:0] step_cnt;
    logic [PERIOD_BITS-1:0] period_m1;
    logic                   tick;
    logic                   pwm_run;

    assign period_m1 = (period == '0) ? '0 : period - PERIOD_ONE;
    // '>=' rather than '==' so a shrinking period ends the current step at once
    // instead of letting step_cnt run all the way round.
    assign tick    = (step_cnt >= period_m1);
    assign busy_o  = (state != IDLE);
    // Gate on enable too so the PWM goes idle on the same edge the FSM does.
    assign pwm_run = enable && (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            level_o      <= '0;
            step_cnt     <= '0;
            cycle_done_o <= 1'b0;
        end else begin
            cycle_done_o <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                level_o  <= '0;
                step_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= INHALE;
                        level_o  <= '0;
                        step_cnt <= '0;
                    end
                    INHALE: begin
                        if (tick) begin
                            step_cnt <= '0;
                            // MAX is held for a second step as the first EXHALE step.
                            if (level_o == LEVEL_MAX) state <= EXHALE;
                            else                      level_o <= level_o + LEVEL_ONE;
                        end else begin
                            step_cnt <= step_cnt + PERIOD_ONE;
                        end
                    end
                    EXHALE: begin
                        if (tick) begin
                            step_cnt <= '0;
                            if (level_o == '0) begin
                                state        <= INHALE;
                                cycle_done_o <= 1'b1;
                            end else begin
                                level_o <= level_o - LEVEL_ONE;
                            end
                        end else begin
                            step_cnt <= step_cnt + PERIOD_ONE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        level_o  <= '0;
                        step_cnt <= '0;
                    end
                endcase
            end
        end
    end

    pwm_compare #(
        .PWM_BITS         (PWM_BITS),
        .OUTPUT_ACTIVE_LOW(OUTPUT_ACTIVE_LOW)
    ) u_pwm (
        .clk  (clk),
        .reset(reset),
        .run  (pwm_run),
        .level(level_o),
        .pwm_o(breathe_o)
    );

endmodule

// File: tb/tb_breathe_pwm_channel.sv
// tb/tb_breathe_pwm_channel.sv - directed self-checking bench for breathe_pwm_channel
module tb_breathe_pwm_channel;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] period;

    logic       breathe;
    logic [2:0] level;
    logic       cycle_done;
    logic       busy;

    logic       breathe_n;
    logic [2:0] level_n;
    logic       cycle_done_n;
    logic       busy_n;

    int checks   = 0;
    int failures = 0;
    int hi;
    int hi_n;
    int pulses;

    always #5 clk = ~clk;

    breathe_pwm_channel #(.PWM_BITS(3), .PERIOD_BITS(24), .OUTPUT_ACTIVE_LOW(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .breathe_o   (breathe),
        .level_o     (level),
        .cycle_done_o(cycle_done),
        .busy_o      (busy)
    );

    breathe_pwm_channel #(.PWM_BITS(3), .PERIOD_BITS(24), .OUTPUT_ACTIVE_LOW(1'b1)) dut_n (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .breathe_o   (breathe_n),
        .level_o     (level_n),
        .cycle_done_o(cycle_done_n),
        .busy_o      (busy_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected level for brightness step s (PWM_BITS=3: 16 steps per cycle).
    function automatic int tri_level(input int s);
        int m;
        m = s % 16;
        return (m < 8) ? m : 15 - m;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_done"}, 32'(cycle_done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_breathe"}, 32'(breathe), 0);
        chk({tag, "_breathe_n"}, 32'(breathe_n), 1);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        period = 24'd4;
        clk_n(2);
        chk_idle("reset");

        reset = 1'b0;
        clk_n(1);

        // Full breathe cycle with period 4: 64 clocks, pulse on the 65th edge.
        enable = 1'b1;
        for (int k = 0; k <= 65; k++) begin
            @(negedge clk);
            chk("t2_level", 32'(level), 32'(tri_level(k / 4)));
            chk("t2_done", 32'(cycle_done), 32'(k == 64));
            chk("t2_busy", 32'(busy), 1);
        end

        // Reset asserted mid-EXHALE, between clock edges.
        clk_n(35);
        chk("t1_pre_level", 32'(level), 6);
        reset = 1'b1;
        #1;
        chk_idle("t1_async");
        clk_n(2);
        chk_idle("t1_held");
        reset = 1'b0;
        for (int k = 0; k <= 63; k++) begin
            @(negedge clk);
            if (k == 0) chk("t1_busy", 32'(busy), 1);
            if (k == 3) chk("t1_level_k3", 32'(level), 0);
            if (k == 4) chk("t1_level_k4", 32'(level), 1);
            if (k == 63) begin
                chk("t6_pre_level", 32'(level), 0);
                enable = 1'b0;
            end
        end

        // Enable dropped on the final EXHALE tick: idle, no pulse.
        @(negedge clk);
        chk_idle("t6_drop");

        enable = 1'b1;
        pulses = 0;
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            pulses += int'(cycle_done);
            if (k == 63) chk("t6_done_k63", 32'(cycle_done), 0);
            if (k == 64) chk("t6_done_k64", 32'(cycle_done), 1);
        end
        chk("t6_pulses", 32'(pulses), 1);

        // period 0 behaves as period 1.
        enable = 1'b0;
        @(negedge clk);
        period = 24'd0;
        enable = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            chk("t4_level", 32'(level), 32'(tri_level(k)));
            chk("t4_done", 32'(cycle_done), 32'(k == 16));
        end

        // PWM duty at level 0.
        enable = 1'b0;
        @(negedge clk);
        period = 24'd1000;
        enable = 1'b1;
        clk_n(3);
        hi = 0; hi_n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi += int'(breathe);
            hi_n += int'(breathe_n);
        end
        chk("t3_l0_hi", 32'(hi), 0);
        chk("t3_l0_hi_n", 32'(hi_n), 16);

        // PWM duty at level 5.
        enable = 1'b0;
        @(negedge clk);
        period = 24'd1;
        enable = 1'b1;
        clk_n(6);
        chk("t3_l5_level", 32'(level), 5);
        period = 24'd1000;
        clk_n(2);
        hi = 0; hi_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hi += int'(breathe);
            hi_n += int'(breathe_n);
        end
        chk("t3_l5_hi", 32'(hi), 5);
        chk("t3_l5_hi_n", 32'(hi_n), 3);

        // Shrink period to 1 for two ticks to reach level 7.
        period = 24'd1;
        clk_n(2);
        chk("t3_l7_level", 32'(level), 7);
        period = 24'd1000;
        clk_n(2);
        hi = 0; hi_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hi += int'(breathe);
            hi_n += int'(breathe_n);
        end
        chk("t3_l7_hi", 32'(hi), 7);
        chk("t3_l7_hi_n", 32'(hi_n), 1);

        // period 100 -> 3 while step_cnt is 50.
        enable = 1'b0;
        @(negedge clk);
        period = 24'd100;
        enable = 1'b1;
        clk_n(51);
        chk("t5_level_t50", 32'(level), 0);
        period = 24'd3;
        @(negedge clk);
        chk("t5_level_t51", 32'(level), 1);
        clk_n(2);
        chk("t5_level_t53", 32'(level), 1);
        clk_n(1);
        chk("t5_level_t54", 32'(level), 2);
        clk_n(3);
        chk("t5_level_t57", 32'(level), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/breathe_pwm_channel.md
Name: breathe_pwm_channel

Overview:
- Single-channel LED "breathing" generator that sits directly downstream of the top-level colour sequencer; one instance per R/G/B LED.
- Produces a triangle brightness ramp 0 → MAX → 0, holding each brightness step for `period` clocks.
- Converts the current brightness into a free-running PWM waveform that drives the LED pad.
- Sequencer drives `enable`; a cycle-complete pulse is returned so the sequencer can switch colour on breathe boundaries instead of a fixed count.

Parameters:
- PWM_BITS, 8, brightness/PWM resolution; MAX = 2^PWM_BITS-1; one breathe cycle = 2^(PWM_BITS+1) steps.
- PERIOD_BITS, 24, width of the `period` input and of the step counter.
- OUTPUT_ACTIVE_LOW, 0, 1 inverts `breathe_o` (LED on = 0). Also sets the idle level.

Ports:
- clk  input  1  system clock (Sys_Clk0 domain).
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = breathe; 0 = return to IDLE with LED dark (synchronous).
- period  input  PERIOD_BITS  clocks per brightness step; 0 treated as 1.
- breathe_o  output  1  registered PWM LED drive.
- level_o  output  PWM_BITS  current brightness (registered).
- cycle_done_o  output  1  one-clock pulse at end of each full inhale+exhale.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset values (async, on reset=1): state=IDLE, level_o=0, step_cnt=0, pwm_cnt=0, cycle_done_o=0, busy_o=0, breathe_o=OUTPUT_ACTIVE_LOW.
- Effective period: period_eff = (period==0) ? 1 : period. Sampled every clock, so a change takes effect mid-step.
- Step tick:
  - Counting: step_cnt increments each clock in INHALE/EXHALE.
  - Tick: tick=1 when step_cnt >= period_eff-1; step_cnt then wraps to 0.
  - The `>=` compare makes a period shrink take effect immediately, with no wrap-around through 2^PERIOD_BITS.
- FSM states and transitions:
  - IDLE: counters held at 0, level 0. Goes to INHALE on the clock where enable=1. The first tick occurs period_eff clocks after entering INHALE.
  - INHALE: on tick, if level==MAX go to EXHALE with level held at MAX; else level+1.
  - EXHALE: on tick, if level==0 go to INHALE and pulse cycle_done_o for exactly 1 clock, with level held at 0; else level-1.
  - Any state with enable=0: next clock goes to IDLE, level=0, step_cnt=0, pwm_cnt=0, no cycle_done pulse.
- Cycle length: levels 0 and MAX are each held for 2 steps, so one cycle = 2^(PWM_BITS+1) steps = period_eff·2^(PWM_BITS+1) clocks.
  - cycle_done_o period = exactly that, measured from the first enable clock.
- PWM:
  - pwm_cnt is PWM_BITS wide and free-runs 0..MAX (wrapping) while busy.
  - Raw on = (pwm_cnt < level), so level 0 is always off and level MAX is on MAX of every 2^PWM_BITS clocks.
  - breathe_o = raw on XOR OUTPUT_ACTIVE_LOW, registered: one-clock latency from pwm_cnt/level.
  - In IDLE, breathe_o = OUTPUT_ACTIVE_LOW.
- Arithmetic: all counters are unsigned. level never over/underflows (saturation is handled by the FSM compares). No combinational path from any input to any output.
- Simultaneous events: enable=0 has priority over tick and cycle_done. Reset has priority over everything.
- Reset mid-cycle: immediate return to the reset values listed above; resumes from level 0 INHALE once reset is released and enable=1.

Decomposition:
- Shared package `breathe_pkg`:
  - state encoding localparams IDLE/INHALE/EXHALE (2 bits);
  - default PWM_BITS/PERIOD_BITS;
  - helper constant STEPS_PER_CYCLE = 1 << (PWM_BITS+1).
- One natural sub-module: `pwm_compare` (pwm_cnt counter + compare + output register + polarity), reused by future dimmer blocks.
- Step counter and FSM stay in the parent.

Test Plan:
1. Reset asserted mid-EXHALE (PWM_BITS=3, period=4) → all outputs return to the reset values within the same cycle. After release with enable=1, level_o starts at 0 and first increments 4 clocks after entering INHALE.
2. PWM_BITS=3, period=4, enable=1 → level_o sequence 0,1..7,7,6..0,0, each value held 4 clocks. cycle_done_o pulses every 64 clocks, one clock wide, coincident with the EXHALE→INHALE transition.
3. Hold at level 5 (PWM_BITS=3) → breathe_o high exactly 5 of every 8 clocks. With level 0 it is never high; with level 7 it is high 7/8. With OUTPUT_ACTIVE_LOW=1 the waveform is inverted and the idle level is 1.
4. period=0 → behaves identically to period=1: level changes every clock, cycle = 16 clocks for PWM_BITS=3.
5. period changed 100→3 while step_cnt=50 → tick on the next clock (>= compare), subsequent steps are 3 clocks long, no ~2^24-clock stall.
6. enable dropped the same clock as the final EXHALE tick → IDLE next clock, cycle_done_o stays 0, breathe_o idle, busy_o=0. Re-enable restarts a full 64-clock cycle.
